// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX frame checker.
// Break detection in the top is enabled by UART_RX_BREAK_DET_EN.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

endpackage

// File: rtl/uart_rx_err_counter.sv
// Saturating error counter; an increment in the same cycle as a
// clear leaves the count at 1.
module uart_rx_err_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            if (clr)
                cnt <= CNT_WIDTH'(1);
            else if (cnt != '1)
                cnt <= cnt + CNT_WIDTH'(1);
        end else if (clr) begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/uart_rx_frame_checker.sv
// UART RX frame checker: deserialises data, checks parity and stop bits.
// Optional break detection is built when UART_RX_BREAK_DET_EN is defined.
module uart_rx_frame_checker
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH           = 8,
    parameter int CNT_WIDTH            = 8,
    parameter int PAR_TYPE_ODD_DEFAULT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  bit_valid,
    input  logic                  bit_value,
    input  logic                  par_en,
    input  logic                  par_type,
    input  logic                  stop_two,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_par_err,
    output logic                  frame_stop_err,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stop_err_cnt,
    output logic                  break_det
);

    localparam int BCW = 4;

    state_t                state, state_nxt;
    logic [BCW-1:0]        bit_cnt;
    logic                  stop_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_q, par_type_q, stop_two_q;
    logic                  f_par_err, f_stop_err;

    logic take, last_stop, complete, par_chk, stop_chk;
    logic par_bad, fpe_nxt, fse_nxt;
    logic is_break, par_upd, stop_upd;

    assign last_stop = (stop_two_q != STOP_TWO) || stop_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = DATA;
        end else if (bit_valid) begin
            unique case (state)
                IDLE:   state_nxt = IDLE;
                DATA: begin
                    if (bit_cnt == BCW'(DATA_WIDTH - 1))
                        state_nxt = par_en_q ? PARITY : STOP;
                end
                PARITY: state_nxt = STOP;
                STOP: begin
                    if (last_stop)
                        state_nxt = IDLE;
                end
            endcase
        end
    end

    // Strobes coinciding with frame_start belong to the start bit.
    always_comb begin
        take     = bit_valid && !frame_start;
        par_chk  = take && (state == PARITY);
        stop_chk = take && (state == STOP);
        complete = stop_chk && last_stop;
    end

    assign par_bad = bit_value != (^shreg ^ (par_type_q == PAR_ODD));
    assign fpe_nxt = f_par_err | (par_chk & par_bad);
    assign fse_nxt = f_stop_err | (stop_chk & ~bit_value);

`ifdef UART_RX_BREAK_DET_EN
    logic zero_q, zero_cur, brk_q;

    assign zero_cur  = stop_idx ? zero_q : (zero_q & ~bit_value);
    assign is_break  = complete & zero_cur;
    assign break_det = brk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            brk_q <= is_break;
            if (frame_start)
                zero_q <= 1'b1;
            else if (take && state != IDLE && !(state == STOP && stop_idx))
                zero_q <= zero_q & ~bit_value;
        end
    end
`else
    assign is_break  = 1'b0;
    assign break_det = 1'b0;
`endif

    assign par_upd  = complete & fpe_nxt;
    assign stop_upd = complete & fse_nxt & ~is_break;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt        <= '0;
            stop_idx       <= 1'b0;
            shreg          <= '0;
            par_en_q       <= 1'b0;
            par_type_q     <= 1'(PAR_TYPE_ODD_DEFAULT);
            stop_two_q     <= STOP_ONE;
            f_par_err      <= 1'b0;
            f_stop_err     <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            frame_par_err  <= 1'b0;
            frame_stop_err <= 1'b0;
            parity_error   <= 1'b0;
            stop_error     <= 1'b0;
        end else begin
            rx_valid     <= complete;
            parity_error <= par_upd | (parity_error & ~err_clr);
            stop_error   <= stop_upd | (stop_error & ~err_clr);
            if (frame_start) begin
                par_en_q   <= par_en;
                par_type_q <= par_type;
                stop_two_q <= stop_two;
                bit_cnt    <= '0;
                stop_idx   <= 1'b0;
                shreg      <= '0;
                f_par_err  <= 1'b0;
                f_stop_err <= 1'b0;
            end else if (take) begin
                unique case (state)
                    IDLE: ;
                    DATA: begin
                        shreg   <= {bit_value, shreg[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                    PARITY: f_par_err <= fpe_nxt;
                    STOP: begin
                        f_stop_err <= fse_nxt;
                        stop_idx   <= !last_stop;
                    end
                endcase
            end
            if (complete) begin
                rx_data        <= shreg;
                frame_par_err  <= fpe_nxt;
                frame_stop_err <= fse_nxt;
            end
        end
    end

    uart_rx_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (par_upd),
        .clr   (err_clr),
        .cnt   (par_err_cnt)
    );

    uart_rx_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stop_upd),
        .clr   (err_clr),
        .cnt   (stop_err_cnt)
    );

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Scoreboard bench for uart_rx_frame_checker (8 data bits, 2-bit counters).
// Break expectations follow UART_RX_BREAK_DET_EN.
module tb_uart_rx_frame_checker;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       frame_start = 0, bit_valid = 0, bit_value = 0;
    logic       par_en = 0, par_type = 0, stop_two = 0, err_clr = 0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_par_err, frame_stop_err;
    logic       parity_error, stop_error, break_det;
    logic [1:0] par_err_cnt, stop_err_cnt;

    uart_rx_frame_checker #(
        .DATA_WIDTH(8), .CNT_WIDTH(2), .PAR_TYPE_ODD_DEFAULT(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .frame_start(frame_start), .bit_valid(bit_valid),
        .bit_value(bit_value), .par_en(par_en), .par_type(par_type),
        .stop_two(stop_two), .err_clr(err_clr),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_par_err(frame_par_err), .frame_stop_err(frame_stop_err),
        .parity_error(parity_error), .stop_error(stop_error),
        .par_err_cnt(par_err_cnt), .stop_err_cnt(stop_err_cnt),
        .break_det(break_det)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit pe, se, brk, ps, ss;
        bit [1:0] pc, sc;
    } exp_t;

    exp_t q[$];
    int tests = 0, fails = 0;

    bit       m_ps = 0, m_ss = 0;
    bit [1:0] m_pc = 0, m_sc = 0;

    function automatic void chk(string n, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", n, act, exp, $time);
        end
    endfunction

    function automatic bit [1:0] sat_inc(bit [1:0] c);
        return (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rx_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rx_data", rx_data, e.d);
                chk("frame_par_err", frame_par_err, e.pe);
                chk("frame_stop_err", frame_stop_err, e.se);
                chk("break_det", break_det, e.brk);
                chk("parity_error", parity_error, e.ps);
                chk("stop_error", stop_error, e.ss);
                chk("par_err_cnt", par_err_cnt, e.pc);
                chk("stop_err_cnt", stop_err_cnt, e.sc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit v, input bit c);
        repeat ($urandom_range(0, 2)) tick();
        bit_valid = 1;
        bit_value = v;
        err_clr = c;
        tick();
        bit_valid = 0;
        err_clr = 0;
        bit_value = 1'($urandom);
    endtask

    task automatic start(input bit pe_en, input bit pt, input bit s2);
        tick();
        frame_start = 1;
        bit_valid = 1'($urandom);
        bit_value = 1'($urandom);
        par_en = pe_en;
        par_type = pt;
        stop_two = s2;
        tick();
        frame_start = 0;
        bit_valid = 0;
        par_en = 1'($urandom);
        par_type = 1'($urandom);
        stop_two = 1'($urandom);
    endtask

    task automatic send(input logic [7:0] d, input bit pe_en, input bit pt,
                        input bit s2, input bit pbit, input bit sb1,
                        input bit sb2, input bit clr);
        exp_t e;
        bit perr, serr, brk;
        perr = pe_en && (pbit != ((^d) ^ pt));
        serr = !sb1 || (s2 && !sb2);
        brk = 0;
`ifdef UART_RX_BREAK_DET_EN
        brk = (d == 8'h00) && (!pe_en || !pbit) && !sb1;
`endif
        m_pc = perr ? (clr ? 2'd1 : sat_inc(m_pc)) : (clr ? 2'd0 : m_pc);
        m_ps = perr ? 1'b1 : (clr ? 1'b0 : m_ps);
        m_sc = (serr && !brk) ? (clr ? 2'd1 : sat_inc(m_sc)) : (clr ? 2'd0 : m_sc);
        m_ss = (serr && !brk) ? 1'b1 : (clr ? 1'b0 : m_ss);
        e.d = d; e.pe = perr; e.se = serr; e.brk = brk;
        e.ps = m_ps; e.ss = m_ss; e.pc = m_pc; e.sc = m_sc;
        q.push_back(e);
        start(pe_en, pt, s2);
        for (int i = 0; i < 8; i++) pulse(d[i], 0);
        if (pe_en) pulse(pbit, 0);
        pulse(sb1, clr && !s2);
        if (s2) pulse(sb2, clr);
    endtask

    task automatic clear();
        tick();
        err_clr = 1;
        tick();
        err_clr = 0;
        m_ps = 0; m_ss = 0; m_pc = 0; m_sc = 0;
        @(negedge clk);
        chk("clr_parity_error", parity_error, 0);
        chk("clr_stop_error", stop_error, 0);
        chk("clr_par_err_cnt", par_err_cnt, 0);
        chk("clr_stop_err_cnt", stop_err_cnt, 0);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_rx_data"}, rx_data, 0);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_flags"}, {frame_par_err, frame_stop_err,
                              parity_error, stop_error, break_det}, 0);
        chk({tag, "_cnts"}, {par_err_cnt, stop_err_cnt}, 0);
    endtask

    initial begin
        #12;
        check_zero("reset");
        rst_n = 1;
        tick();

        send(8'hA5, 1, 0, 0, 0, 1, 1, 0);
        send(8'hA5, 1, 0, 0, 1, 1, 1, 0);
        send(8'h96, 1, 1, 0, 1, 1, 1, 0);
        send(8'h3C, 0, 0, 1, 0, 1, 0, 0);
        clear();

        for (int i = 0; i < 5; i++) send(8'($urandom), 0, 0, 0, 0, 0, 1, 0);
        send(8'h11, 0, 0, 1, 0, 1, 0, 1);

        start(1, 0, 0);
        for (int i = 0; i < 4; i++) pulse(1'($urandom), 0);
        send(8'h5A, 0, 0, 0, 0, 1, 1, 0);

        send(8'h00, 0, 0, 0, 0, 0, 1, 0);
        send(8'h00, 1, 0, 1, 0, 0, 1, 0);

        for (int i = 0; i < 60; i++) begin
            logic [7:0] d;
            bit pe_en, pt, pbit;
            d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            pe_en = 1'($urandom);
            pt = 1'($urandom);
            pbit = ((^d) ^ pt) ^ ($urandom_range(0, 3) == 0);
            if (d == 8'h00 && $urandom_range(0, 1) == 1) pbit = 0;
            if ($urandom_range(0, 5) == 0) pulse(1'($urandom), 0);
            send(d, pe_en, pt, 1'($urandom), pbit,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 9) == 0);
        end

        start(1, 1, 1);
        for (int i = 0; i < 3; i++) pulse(1'($urandom), 0);
        rst_n = 0;
        #2;
        check_zero("async_rst");
        m_ps = 0; m_ss = 0; m_pc = 0; m_sc = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 12; i++) pulse(1'($urandom), 0);
        send(8'hC3, 1, 1, 0, 1, 1, 1, 0);

        repeat (5) tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: timeout, pending %0d", q.size());
        $fatal(1, "timeout");
    end

endmodule
